beta_recursion: RTL

BETA_RECURSION -- requirements
Module: beta_recursion

---
 rtl/map_pkg.sv | 39 +++
 rtl/beta_acs.sv | 22 ++
 rtl/beta_recursion.sv | 139 +++++++++++++
 3 files changed

// File: rtl/map_pkg.sv
// Shared types and trellis tables for the max-log-MAP backward recursion.
// 8-state RSC, feedback 1+D^2+D^3, feedforward 1+D+D^3; state = {s1,s2,s3}.
package map_pkg;

  localparam int N_STATES = 8;
  localparam int METRIC_W = 16;
  localparam int NEG_INIT = -16384;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RUN,
    LAST,
    DONE
  } state_e;

  localparam logic [2:0] NEXT [N_STATES][2] = '{
    '{3'd0, 3'd4},
    '{3'd4, 3'd0},
    '{3'd5, 3'd1},
    '{3'd1, 3'd5},
    '{3'd2, 3'd6},
    '{3'd6, 3'd2},
    '{3'd7, 3'd3},
    '{3'd3, 3'd7}
  };

  localparam logic PAR [N_STATES][2] = '{
    '{1'b0, 1'b1},
    '{1'b0, 1'b1},
    '{1'b1, 1'b0},
    '{1'b1, 1'b0},
    '{1'b1, 1'b0},
    '{1'b1, 1'b0},
    '{1'b0, 1'b1},
    '{1'b0, 1'b1}
  };

endpackage

// File: rtl/beta_acs.sv
// Add-compare-select for one state: the larger of two beta+gamma candidates.
// Sums are widened by two bits so they never wrap.
module beta_acs #(
  parameter int W = 16
) (
  input  logic signed [W-1:0] beta0,
  input  logic signed [W-1:0] beta1,
  input  logic signed [W-1:0] gamma0,
  input  logic signed [W-1:0] gamma1,
  output logic signed [W+1:0] beta_max
);

  logic signed [W+1:0] c0;
  logic signed [W+1:0] c1;

  always_comb begin
    c0 = {{2{beta0[W-1]}}, beta0} + {{2{gamma0[W-1]}}, gamma0};
    c1 = {{2{beta1[W-1]}}, beta1} + {{2{gamma1[W-1]}}, gamma1};
    beta_max = (c1 > c0) ? c1 : c0;
  end

endmodule

// File: rtl/beta_recursion.sv
// Backward (beta) recursion of a max-log-MAP decoder for one block.
// Writes terminal beta then beta_k for k = BLK_LEN-1 .. 0 to the beta SRAM.
module beta_recursion #(
  parameter int BLK_LEN  = 8,
  parameter int METRIC_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [4*METRIC_W-1:0]   gamma_in,
  input  logic                    gamma_valid,
  output logic                    gamma_ready,
  output logic                    mem_wr,
  output logic [7:0]              mem_addr,
  output logic [8*METRIC_W-1:0]   mem_data,
  output logic                    busy,
  output logic                    done
);
  import map_pkg::*;

  localparam int SW = METRIC_W + 2;
  localparam logic [4:0] K_LAST = 5'(BLK_LEN - 1);
  localparam logic [7:0] TERM_ADDR = 8'(8 * BLK_LEN);
  localparam logic signed [SW-1:0] SAT_HI = SW'((1 << (METRIC_W - 1)) - 1);
  localparam logic signed [SW-1:0] SAT_LO = -SAT_HI - SW'(1);
  localparam logic signed [METRIC_W-1:0] NEG_M = METRIC_W'(NEG_INIT);

  state_e state_q, state_d;
  logic [4:0] k_q, k_d;
  logic signed [METRIC_W-1:0] beta_q [N_STATES];
  logic signed [METRIC_W-1:0] beta_d [N_STATES];
  logic mem_wr_q, mem_wr_d;
  logic [7:0] addr_q, addr_d;
  logic [8*METRIC_W-1:0] data_q, data_d;

  logic signed [METRIC_W-1:0] gam [4];
  logic signed [SW-1:0] acs_max [N_STATES];
  logic signed [SW-1:0] nrm [N_STATES];
  logic signed [METRIC_W-1:0] new_b [N_STATES];
  logic signed [METRIC_W-1:0] term_b [N_STATES];
  logic [8*METRIC_W-1:0] term_v, new_v;

  for (genvar l = 0; l < 4; l++) begin : g_lane
    assign gam[l] = gamma_in[METRIC_W*l +: METRIC_W];
  end

  for (genvar s = 0; s < N_STATES; s++) begin : g_acs
    beta_acs #(.W(METRIC_W)) u_acs (
      .beta0   (beta_q[NEXT[s][0]]),
      .beta1   (beta_q[NEXT[s][1]]),
      .gamma0  (gam[{1'b0, PAR[s][0]}]),
      .gamma1  (gam[{1'b1, PAR[s][1]}]),
      .beta_max(acs_max[s])
    );
  end

  // Normalise to state 0 so metrics stay bounded across the block.
  always_comb begin
    for (int s = 0; s < N_STATES; s++) begin
      nrm[s] = acs_max[s] - acs_max[0];
      if (nrm[s] > SAT_HI) begin
        new_b[s] = SAT_HI[METRIC_W-1:0];
      end else if (nrm[s] < SAT_LO) begin
        new_b[s] = SAT_LO[METRIC_W-1:0];
      end else begin
        new_b[s] = nrm[s][METRIC_W-1:0];
      end
      term_b[s] = (s == 0) ? '0 : NEG_M;
      new_v[METRIC_W*s +: METRIC_W] = new_b[s];
      term_v[METRIC_W*s +: METRIC_W] = term_b[s];
    end
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    beta_d   = beta_q;
    mem_wr_d = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = INIT;
          mem_wr_d = 1'b1;
          addr_d   = TERM_ADDR;
          data_d   = term_v;
        end
      end
      INIT: begin
        beta_d  = term_b;
        k_d     = K_LAST;
        state_d = RUN;
      end
      RUN: begin
        if (gamma_valid) begin
          beta_d   = new_b;
          data_d   = new_v;
          mem_wr_d = 1'b1;
          addr_d   = {k_q, 3'b000};
          if (k_q == '0) begin
            state_d = LAST;
          end else begin
            k_d = k_q - 5'd1;
          end
        end
      end
      LAST:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      mem_wr_q <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      for (int s = 0; s < N_STATES; s++) beta_q[s] <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      mem_wr_q <= mem_wr_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      beta_q   <= beta_d;
    end
  end

  assign gamma_ready = (state_q == RUN);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign mem_wr      = mem_wr_q;
  assign mem_addr    = addr_q;
  assign mem_data    = data_q;

endmodule
